// File: rtl/timer_peripheral_pkg.sv
// Shared address map and register field definitions for the timer peripheral.
// Building with TIMER_IRQ_EN defined enables the PEND status bit and the irq line.
package timer_peripheral_pkg;

   localparam logic [31:0] TIMER_ADDRESS = 32'h0000_2000;

   localparam logic [1:0] TIMER_CNT27 = 2'd0;
   localparam logic [1:0] TIMER_CNT1M = 2'd1;
   localparam logic [1:0] TIMER_CMP   = 2'd2;
   localparam logic [1:0] TIMER_CTRL  = 2'd3;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_PEND_BIT = 1;
   localparam int CTRL_AUTO_BIT = 2;

   function automatic logic [31:0] ctrl_word(input logic en, input logic pend, input logic auto_rl);
      logic [31:0] w;
      w = 32'd0;
      w[CTRL_EN_BIT]   = en;
      w[CTRL_PEND_BIT] = pend;
      w[CTRL_AUTO_BIT] = auto_rl;
      return w;
   endfunction

endpackage

// File: rtl/timer_peripheral_tick_divider.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled clocks; en=0 freezes the phase.
module tick_divider #(
   parameter int PRESCALE = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;
   logic       wrap_s;

   // Phase counter next-state
   always_comb begin
      cnt_d  = cnt_q;
      wrap_s = (cnt_q == 8'(PRESCALE - 1));
      if (en) begin
         if (wrap_s) begin
            cnt_d = 8'd0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Phase counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && wrap_s;

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped timer: 27 MHz and 1 MHz counters, compare/alarm, control/status and irq.
// Optional macro TIMER_IRQ_EN enables the PEND bit and the irq output.
module timer_peripheral
   import timer_peripheral_pkg::*;
#(
   parameter int          PRESCALE  = 27,
   parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic        ren,
   input  logic        wen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq,
   output logic [31:0] counter27M,
   output logic [31:0] counter1M
);

   logic [31:0] cnt27_q, cnt27_d;
   logic [31:0] cnt1m_q, cnt1m_d;
   logic [31:0] cmp_q, cmp_d;
   logic [31:0] rdata_q, rdata_d;
   logic        en_q, en_d;
   logic        auto_q, auto_d;
   logic        pend_q, pend_d;
   logic        tick_s, wr_s, rd_s, cnt1m_wr_s, match_s;
   logic [31:0] next_1m_s;

   tick_divider #(.PRESCALE(PRESCALE)) u_tick_divider (
      .clk  (clk),
      .rst  (rst),
      .en   (en_q),
      .tick (tick_s)
   );

   // Next-state for counters, CPU-visible registers and read data
   always_comb begin
      wr_s       = sel & wen;
      rd_s       = sel & ren;
      next_1m_s  = cnt1m_q + 32'd1;
      cnt27_d    = cnt27_q + 32'd1;
      cnt1m_d    = cnt1m_q;
      cmp_d      = cmp_q;
      en_d       = en_q;
      auto_d     = auto_q;
      pend_d     = pend_q;
      rdata_d    = rdata_q;
      cnt1m_wr_s = wr_s && (addr == TIMER_CNT1M);
      // A CPU load of CNT1M overrides the tick and suppresses the compare.
      match_s    = tick_s && !cnt1m_wr_s && (next_1m_s == cmp_q);

      if (cnt1m_wr_s) begin
         cnt1m_d = wdata;
      end else if (tick_s) begin
         cnt1m_d = (match_s && auto_q) ? 32'd0 : next_1m_s;
      end else begin
         cnt1m_d = cnt1m_q;
      end

      if (wr_s) begin
         case (addr)
            TIMER_CMP: cmp_d = wdata;
            TIMER_CTRL: begin
               en_d   = wdata[CTRL_EN_BIT];
               auto_d = wdata[CTRL_AUTO_BIT];
            end
            default: cmp_d = cmp_q;
         endcase
      end else begin
         cmp_d = cmp_q;
      end

`ifdef TIMER_IRQ_EN
      if (match_s) begin
         pend_d = 1'b1;
      end else if (wr_s && (addr == TIMER_CTRL) && wdata[CTRL_PEND_BIT]) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end
`else
      pend_d = 1'b0;
`endif

      if (rd_s) begin
         case (addr)
            TIMER_CNT27: rdata_d = cnt27_q;
            TIMER_CNT1M: rdata_d = cnt1m_q;
            TIMER_CMP:   rdata_d = cmp_q;
            TIMER_CTRL:  rdata_d = ctrl_word(en_q, pend_q, auto_q);
            default:     rdata_d = 32'd0;
         endcase
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt27_q <= 32'd0;
         cnt1m_q <= 32'd0;
         cmp_q   <= CMP_RESET;
         rdata_q <= 32'd0;
         en_q    <= 1'b1;
         auto_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         cnt27_q <= cnt27_d;
         cnt1m_q <= cnt1m_d;
         cmp_q   <= cmp_d;
         rdata_q <= rdata_d;
         en_q    <= en_d;
         auto_q  <= auto_d;
         pend_q  <= pend_d;
      end
   end

   assign rdata      = rdata_q;
   assign counter27M = cnt27_q;
   assign counter1M  = cnt1m_q;
`ifdef TIMER_IRQ_EN
   assign irq = pend_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed testbench for timer_peripheral; expectations follow the TIMER_IRQ_EN build setting.
module tb_timer_peripheral;

`ifdef TIMER_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        sel;
   logic [1:0]  addr;
   logic        ren;
   logic        wen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   logic [31:0] counter27M;
   logic [31:0] counter1M;

   int checks = 0;
   int errors = 0;

   timer_peripheral #(.PRESCALE(27), .CMP_RESET(32'hFFFF_FFFF)) dut (
      .clk        (clk),
      .rst        (rst),
      .sel        (sel),
      .addr       (addr),
      .ren        (ren),
      .wen        (wen),
      .wdata      (wdata),
      .rdata      (rdata),
      .irq        (irq),
      .counter27M (counter27M),
      .counter1M  (counter1M)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; sel = 1'b0; ren = 1'b0; wen = 1'b0; addr = 2'd0; wdata = 32'd0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
      sel = 1'b1; wen = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; wen = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] a);
      sel = 1'b1; ren = 1'b1; addr = a;
      @(negedge clk);
      sel = 1'b0; ren = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (counter27M !== 32'd0) begin errors++; $display("FAIL rst_cnt27: got %0d expected 0", counter27M); end
      checks++; if (counter1M !== 32'd0) begin errors++; $display("FAIL rst_cnt1m: got %0d expected 0", counter1M); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
      checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
   endtask

   task automatic test_count();
      step(270);
      checks++; if (counter27M !== 32'd270) begin errors++; $display("FAIL cnt27_270: got %0d expected 270", counter27M); end
      checks++; if (counter1M !== 32'd10) begin errors++; $display("FAIL cnt1m_10: got %0d expected 10", counter1M); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
      read_reg(2'd0);
      checks++; if (rdata !== 32'd270) begin errors++; $display("FAIL read_cnt27: got %0d expected 270", rdata); end
      step(3);
      checks++; if (rdata !== 32'd270) begin errors++; $display("FAIL rdata_hold: got %0d expected 270", rdata); end
      // edge 275: strobes without sel
      sel = 1'b0; wen = 1'b1; ren = 1'b1; addr = 2'd1; wdata = 32'hDEAD;
      @(negedge clk);
      wen = 1'b0; ren = 1'b0;
      checks++; if (counter1M !== 32'd10) begin errors++; $display("FAIL nosel_write: got %0d expected 10", counter1M); end
      checks++; if (rdata !== 32'd270) begin errors++; $display("FAIL nosel_read: got %0d expected 270", rdata); end
      write_reg(2'd0, 32'd5);
      checks++; if (counter27M !== 32'd276) begin errors++; $display("FAIL cnt27_ro: got %0d expected 276", counter27M); end
   endtask

   task automatic test_rw_same_cycle();
      sel = 1'b1; wen = 1'b1; ren = 1'b1; addr = 2'd1; wdata = 32'd77;
      @(negedge clk);
      sel = 1'b0; wen = 1'b0; ren = 1'b0;
      checks++; if (rdata !== 32'd10) begin errors++; $display("FAIL rw_old_value: got %0d expected 10", rdata); end
      checks++; if (counter1M !== 32'd77) begin errors++; $display("FAIL rw_write: got %0d expected 77", counter1M); end
   endtask

   task automatic test_auto_reload();
      do_reset();
      write_reg(2'd2, 32'd5);
      write_reg(2'd3, 32'h5);
      step(132);
      checks++; if (counter1M !== 32'd4) begin errors++; $display("FAIL auto_pre: got %0d expected 4", counter1M); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL auto_irq_pre: got %b expected 0", irq); end
      step(1);
      checks++; if (counter1M !== 32'd0) begin errors++; $display("FAIL auto_wrap: got %0d expected 0", counter1M); end
      checks++; if (irq !== IRQ_ON) begin errors++; $display("FAIL auto_irq: got %b expected %b", irq, IRQ_ON); end
      step(27);
      checks++; if (counter1M !== 32'd1) begin errors++; $display("FAIL auto_next: got %0d expected 1", counter1M); end
      step(108);
      checks++; if (counter1M !== 32'd0) begin errors++; $display("FAIL auto_period: got %0d expected 0", counter1M); end
      read_reg(2'd3);
      checks++; if (rdata !== (IRQ_ON ? 32'h7 : 32'h5)) begin errors++; $display("FAIL ctrl_read: got %h expected %h", rdata, (IRQ_ON ? 32'h7 : 32'h5)); end
   endtask

   task automatic test_w1c();
      do_reset();
      write_reg(2'd2, 32'd2);
      write_reg(2'd3, 32'h5);
      step(51);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_pre: got %b expected 0", irq); end
      write_reg(2'd3, 32'h7);
      checks++; if (irq !== IRQ_ON) begin errors++; $display("FAIL w1c_set_wins: got %b expected %b", irq, IRQ_ON); end
      checks++; if (counter1M !== 32'd0) begin errors++; $display("FAIL w1c_reload: got %0d expected 0", counter1M); end
      write_reg(2'd3, 32'h7);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %b expected 0", irq); end
   endtask

   task automatic test_wrap_and_load();
      do_reset();
      write_reg(2'd1, 32'hFFFF_FFFE);
      write_reg(2'd2, 32'd0);
      step(25);
      checks++; if (counter1M !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_max: got %h expected ffffffff", counter1M); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wrap_irq_pre: got %b expected 0", irq); end
      step(27);
      checks++; if (counter1M !== 32'd0) begin errors++; $display("FAIL wrap_zero: got %h expected 0", counter1M); end
      checks++; if (irq !== IRQ_ON) begin errors++; $display("FAIL wrap_irq: got %b expected %b", irq, IRQ_ON); end
      step(26);
      write_reg(2'd1, 32'd100);
      checks++; if (counter1M !== 32'd100) begin errors++; $display("FAIL load_on_tick: got %0d expected 100", counter1M); end
      step(26);
      checks++; if (counter1M !== 32'd100) begin errors++; $display("FAIL load_hold: got %0d expected 100", counter1M); end
      step(1);
      checks++; if (counter1M !== 32'd101) begin errors++; $display("FAIL load_next: got %0d expected 101", counter1M); end
   endtask

   task automatic test_enable();
      do_reset();
      step(39);
      write_reg(2'd3, 32'h0);
      checks++; if (counter1M !== 32'd1) begin errors++; $display("FAIL en_pre: got %0d expected 1", counter1M); end
      step(500);
      checks++; if (counter1M !== 32'd1) begin errors++; $display("FAIL en_frozen: got %0d expected 1", counter1M); end
      checks++; if (counter27M !== 32'd540) begin errors++; $display("FAIL en_cnt27: got %0d expected 540", counter27M); end
      write_reg(2'd3, 32'h1);
      step(13);
      checks++; if (counter1M !== 32'd1) begin errors++; $display("FAIL en_phase_hold: got %0d expected 1", counter1M); end
      step(1);
      checks++; if (counter1M !== 32'd2) begin errors++; $display("FAIL en_resume: got %0d expected 2", counter1M); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      write_reg(2'd2, 32'd1);
      step(26);
      checks++; if (irq !== IRQ_ON) begin errors++; $display("FAIL mr_irq_set: got %b expected %b", irq, IRQ_ON); end
      read_reg(2'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (counter27M !== 32'd0) begin errors++; $display("FAIL mr_cnt27: got %0d expected 0", counter27M); end
      checks++; if (counter1M !== 32'd0) begin errors++; $display("FAIL mr_cnt1m: got %0d expected 0", counter1M); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mr_irq: got %b expected 0", irq); end
      checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL mr_rdata: got %h expected 0", rdata); end
      read_reg(2'd2);
      checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mr_cmp: got %h expected ffffffff", rdata); end
      read_reg(2'd3);
      checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL mr_ctrl: got %h expected 1", rdata); end
      step(24);
      checks++; if (counter1M !== 32'd0) begin errors++; $display("FAIL mr_phase_pre: got %0d expected 0", counter1M); end
      step(1);
      checks++; if (counter1M !== 32'd1) begin errors++; $display("FAIL mr_phase: got %0d expected 1", counter1M); end
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; ren = 1'b0; wen = 1'b0; addr = 2'd0; wdata = 32'd0;
      test_reset();
      test_count();
      test_rw_same_cycle();
      test_auto_reload();
      test_w1c();
      test_wrap_and_load();
      test_enable();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_peripheral.md
Name: timer_peripheral

Overview:
Memory-mapped timer responder on the core's data bus. It sits behind the address decoder, which asserts sel for the timer window.
- Owns the free-running 27 MHz cycle counter and the prescaled 1 MHz counter.
- Adds a compare/alarm register, a control/status register and an interrupt line.
- Also drives counter27M and counter1M as direct outputs for the existing decoder read paths.

Parameters:
- PRESCALE, 27: clk cycles per 1M tick; legal range 2..255.
- CMP_RESET, 32'hFFFF_FFFF: reset value of the compare register.

Ports:
- clk  in  1  system clock (27 MHz)
- rst  in  1  synchronous, active-high reset
- sel  in  1  decoder select: address lies in the timer window
- addr  in  2  word offset, data_addr[3:2]
- ren  in  1  read strobe, qualified by sel
- wen  in  1  write strobe, qualified by sel
- wdata  in  32  write data
- rdata  out  32  registered read data
- irq  out  1  level interrupt, equal to status.pending
- counter27M  out  32  free-running cycle count
- counter1M  out  32  prescaled tick count

Behaviour:
Register map (word offsets):
- 0: CNT27 (RO)
- 1: CNT1M (RW)
- 2: CMP (RW)
- 3: CTRL, bit0 EN (RW), bit1 PEND (W1C), bit2 AUTO (RW); other bits read 0, writes to them are ignored

Reset, on rst high at a clk edge:
- counter27M=0, counter1M=0, prescale count=0, CMP=CMP_RESET
- EN=1, AUTO=0, PEND=0, irq=0, rdata=0
- rst mid-operation aborts everything; the tick phase restarts at 0.

counter27M:
- Increments every cycle, independent of EN.
- Wraps 0xFFFF_FFFF -> 0.

Prescaler:
- Counts 0..PRESCALE-1 while EN=1, then wraps.
- tick=1 for one cycle when the count equals PRESCALE-1.
- EN=0 freezes the prescale count; it does not clear it.

On tick:
- next = counter1M+1, wrapping at 32 bits.
- If next==CMP: PEND<=1, and counter1M <= (AUTO ? 0 : next).
- Otherwise counter1M <= next.

CPU access:
- Strobes are qualified by sel; a write needs sel&wen, a read needs sel&ren.
- Write to CNT1M: loads wdata and wins over a same-cycle tick. No match is evaluated that cycle.
- Write to CMP: takes effect from the next tick.
- Write to CTRL: EN<=wdata[0], AUTO<=wdata[2]. PEND clears if wdata[1]=1.
- If a match sets PEND in the same cycle as a W1C, the set wins and PEND stays 1.
- Write to CNT27: ignored.
- Read latency is 1 cycle. The rdata of the addressed register is valid on the cycle after sel&ren and is held until the next read.
- The read value is the register contents before any same-cycle update.
- sel&ren&wen together: the write and the read both happen; the read returns the old value.
- Strobes with sel=0 have no effect and rdata holds.

irq:
- Registered: irq equals PEND, same cycle as PEND.
- Stays asserted until software clears PEND.

Optional Feature:
TIMER_IRQ_EN.
- Defined: PEND logic and the irq output are as described.
- Undefined:
  - irq is tied 0.
  - CTRL bit1 reads 0 and writes to it are ignored.
  - Compare matches still auto-reload when AUTO=1.
  - The CMP register remains.

Decomposition:
- Shared header config.vh (the existing address-map header) holds:
  - TIMER_ADDRESS base;
  - word offset constants TIMER_CNT27, TIMER_CNT1M, TIMER_CMP, TIMER_CTRL;
  - CTRL bit index constants;
  - TIMER_IRQ_EN.
- The decoder uses TIMER_ADDRESS to generate sel.
- One natural sub-module, tick_divider: parameter PRESCALE; inputs clk, rst, en; output tick.

Test Plan:
1. Reset, then 270 cycles with EN=1 -> counter27M=270, counter1M=10, irq=0. Read offset 0 -> rdata holds the pre-read count one cycle later.
2. Write CMP=5, AUTO=1 -> PEND/irq rise at the 5th tick. counter1M goes to 0 that tick and is 0..4 thereafter, with a period of 5 ticks (135 cycles).
3. Write CTRL=0x2 while PEND=1 -> irq falls next cycle. Then force a W1C on the exact cycle of a match -> PEND stays 1.
4. Write CNT1M=0xFFFF_FFFE, CMP=0 -> next tick counter1M=0xFFFF_FFFF, following tick counter1M=0 with PEND=1. Also write CNT1M=100 on a tick cycle -> counter1M=100, not 101.
5. EN=0 for 500 cycles -> counter1M unchanged, counter27M +500. Re-enable at prescale phase 13 -> first tick after 14 cycles.
6. Assert rst mid-count and during a pending irq -> all outputs zero on the next edge, CMP=0xFFFF_FFFF. Build without TIMER_IRQ_EN -> scenario 2 shows irq=0 and CTRL bit1 reading 0.
